// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared BTB widths, way field layout, FSM encodings and helpers
package btb_pkg;

    localparam int IDX_W    = 3;
    localparam int TAG_W    = 27;
    localparam int TGT_W    = 32;
    localparam int WAY_W    = 64;
    localparam int SET_W    = 2 * WAY_W;
    localparam int WAY1_OFF = 64;
    localparam int WAY2_OFF = 0;

    localparam logic [1:0] FSM_STRONG_T  = 2'b00;
    localparam logic [1:0] FSM_WEAK_T    = 2'b01;
    localparam logic [1:0] FSM_WEAK_NT   = 2'b10;
    localparam logic [1:0] FSM_STRONG_NT = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        logic [1:0]       fsm;
        logic [1:0]       rsvd;
    } way_t;

    // Both taken encodings have a clear MSB.
    function automatic logic is_taken(input logic [1:0] fsm);
        return (fsm == FSM_STRONG_T) || (fsm == FSM_WEAK_T);
    endfunction

endpackage

// File: rtl/btb_way_match.sv
// rtl/btb_way_match.sv - unpack one BTB way, compare its tag, decode taken
module btb_way_match
    import btb_pkg::*;
(
    input  logic [WAY_W-1:0] way_bits,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic             taken,
    output logic [TGT_W-1:0] target
);

    way_t w;
    logic unused_rsvd;

    assign w           = way_t'(way_bits);
    assign hit         = w.valid && (w.tag == tag);
    assign taken       = is_taken(w.fsm);
    assign target      = w.target;
    assign unused_rsvd = ^w.rsvd;

endmodule

// File: rtl/btb_lookup.sv
// rtl/btb_lookup.sv - two-way BTB storage, registered fetch prediction and write port
module btb_lookup
    import btb_pkg::*;
#(
    parameter int NSETS = 8,
    parameter int IDX_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lookup_valid,
    input  logic [31:0]        lookup_pc,
    input  logic               stall,
    output logic               pred_valid,
    output logic               pred_hit,
    output logic               pred_way,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output logic [31:0]        pred_next_pc,
    input  logic [31:0]        upd_pc,
    output logic [SET_W-1:0]   old_set,
    output logic               lru_victim,
    output logic               upd_hit1,
    output logic               upd_hit2,
    input  logic               write_en,
    input  logic [SET_W-1:0]   write_set,
    input  logic               write_alloc
);

    logic [SET_W-1:0] array_q [NSETS];
    logic [SET_W-1:0] array_d [NSETS];
    logic [NSETS-1:0] lru_q, lru_d;

    logic        pred_valid_q, pred_valid_d;
    logic        pred_hit_q, pred_hit_d;
    logic        pred_way_q, pred_way_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic [31:0] pred_next_pc_q, pred_next_pc_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic [SET_W-1:0] lk_set, upd_set;

    logic             lk_hit1, lk_hit2, lk_taken1, lk_taken2;
    logic [TGT_W-1:0] lk_tgt1, lk_tgt2;
    logic             lk_hit, lk_way, lk_taken;
    logic [31:0]      lk_target, lk_next_pc;

    logic             up_hit1, up_hit2;
    logic             unused_up_taken1, unused_up_taken2;
    logic [TGT_W-1:0] unused_up_tgt1, unused_up_tgt2;
    logic             unused_upd_lo;

    assign lk_idx        = lookup_pc[IDX_W+1:2];
    assign upd_idx       = upd_pc[IDX_W+1:2];
    assign lk_tag        = TAG_W'(lookup_pc >> (IDX_W + 2));
    assign upd_tag       = TAG_W'(upd_pc >> (IDX_W + 2));
    assign unused_upd_lo = ^{upd_pc[1:0], upd_pc[IDX_W+1:2]};

    // A same-index write this cycle is forwarded so fetch never sees a stale set.
    always_comb begin
        lk_set = array_q[lk_idx];
        if (write_en && (upd_idx == lk_idx)) begin
            lk_set = write_set;
        end
    end

    btb_way_match u_lk_w1 (
        .way_bits (lk_set[WAY1_OFF +: WAY_W]),
        .tag      (lk_tag),
        .hit      (lk_hit1),
        .taken    (lk_taken1),
        .target   (lk_tgt1)
    );

    btb_way_match u_lk_w2 (
        .way_bits (lk_set[WAY2_OFF +: WAY_W]),
        .tag      (lk_tag),
        .hit      (lk_hit2),
        .taken    (lk_taken2),
        .target   (lk_tgt2)
    );

    always_comb begin
        lk_hit     = lk_hit1 | lk_hit2;
        lk_way     = ~lk_hit1 & lk_hit2;
        lk_taken   = lk_hit1 ? lk_taken1 : (lk_hit2 & lk_taken2);
        lk_target  = lk_hit1 ? lk_tgt1 : (lk_hit2 ? lk_tgt2 : 32'd0);
        lk_next_pc = lk_taken ? lk_target : (lookup_pc + 32'd4);
    end

    // Write-side view is the pre-write array, deliberately unbypassed.
    assign upd_set    = array_q[upd_idx];
    assign old_set    = upd_set;
    assign lru_victim = lru_q[upd_idx];

    btb_way_match u_up_w1 (
        .way_bits (upd_set[WAY1_OFF +: WAY_W]),
        .tag      (upd_tag),
        .hit      (up_hit1),
        .taken    (unused_up_taken1),
        .target   (unused_up_tgt1)
    );

    btb_way_match u_up_w2 (
        .way_bits (upd_set[WAY2_OFF +: WAY_W]),
        .tag      (upd_tag),
        .hit      (up_hit2),
        .taken    (unused_up_taken2),
        .target   (unused_up_tgt2)
    );

    assign upd_hit1 = up_hit1;
    assign upd_hit2 = up_hit2 & ~up_hit1;

    always_comb begin
        pred_valid_d   = pred_valid_q;
        pred_hit_d     = pred_hit_q;
        pred_way_d     = pred_way_q;
        pred_taken_d   = pred_taken_q;
        pred_target_d  = pred_target_q;
        pred_next_pc_d = pred_next_pc_q;
        array_d        = array_q;
        lru_d          = lru_q;

        if (!stall) begin
            pred_valid_d = lookup_valid;
            if (lookup_valid) begin
                pred_hit_d     = lk_hit;
                pred_way_d     = lk_way;
                pred_taken_d   = lk_taken;
                pred_target_d  = lk_target;
                pred_next_pc_d = lk_next_pc;
                if (lk_hit) begin
                    lru_d[lk_idx] = ~lk_way;
                end
            end
        end

        // Applied last so an allocating write overrides a same-index hit update.
        if (write_en) begin
            array_d[upd_idx] = write_set;
            if (write_alloc) begin
                lru_d[upd_idx] = ~lru_q[upd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            array_q        <= '{default: '0};
            lru_q          <= '0;
            pred_valid_q   <= 1'b0;
            pred_hit_q     <= 1'b0;
            pred_way_q     <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_target_q  <= '0;
            pred_next_pc_q <= '0;
        end else begin
            array_q        <= array_d;
            lru_q          <= lru_d;
            pred_valid_q   <= pred_valid_d;
            pred_hit_q     <= pred_hit_d;
            pred_way_q     <= pred_way_d;
            pred_taken_q   <= pred_taken_d;
            pred_target_q  <= pred_target_d;
            pred_next_pc_q <= pred_next_pc_d;
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_hit     = pred_hit_q;
    assign pred_way     = pred_way_q;
    assign pred_taken   = pred_taken_q;
    assign pred_target  = pred_target_q;
    assign pred_next_pc = pred_next_pc_q;

endmodule

// File: tb/tb_btb_lookup.sv
// tb/tb_btb_lookup.sv - directed self-checking bench for btb_lookup
module tb_btb_lookup;

    logic         clk = 1'b0;
    logic         rst;
    logic         lookup_valid;
    logic [31:0]  lookup_pc;
    logic         stall;
    logic         pred_valid, pred_hit, pred_way, pred_taken;
    logic [31:0]  pred_target, pred_next_pc;
    logic [31:0]  upd_pc;
    logic [127:0] old_set;
    logic         lru_victim, upd_hit1, upd_hit2;
    logic         write_en;
    logic [127:0] write_set;
    logic         write_alloc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_lookup #(.NSETS(8), .IDX_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .stall        (stall),
        .pred_valid   (pred_valid),
        .pred_hit     (pred_hit),
        .pred_way     (pred_way),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_next_pc (pred_next_pc),
        .upd_pc       (upd_pc),
        .old_set      (old_set),
        .lru_victim   (lru_victim),
        .upd_hit1     (upd_hit1),
        .upd_hit2     (upd_hit2),
        .write_en     (write_en),
        .write_set    (write_set),
        .write_alloc  (write_alloc)
    );

    function automatic logic [63:0] mk_way(input logic v, input logic [26:0] tag,
                                           input logic [31:0] tgt, input logic [1:0] fsm);
        return {v, tag, tgt, fsm, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pred(input string tag, input logic v, input logic h, input logic w,
                            input logic t, input logic [31:0] tgt, input logic [31:0] npc);
        chk({tag, ".valid"},  128'(pred_valid),   128'(v));
        chk({tag, ".hit"},    128'(pred_hit),     128'(h));
        chk({tag, ".way"},    128'(pred_way),     128'(w));
        chk({tag, ".taken"},  128'(pred_taken),   128'(t));
        chk({tag, ".target"}, 128'(pred_target),  128'(tgt));
        chk({tag, ".next"},   128'(pred_next_pc), 128'(npc));
    endtask

    logic [127:0] set_a, set_b, set_c, set_d, set_e;

    initial begin
        set_a = {mk_way(1'b1, 27'h80, 32'h2000, 2'b00), 64'h0};
        set_b = {mk_way(1'b1, 27'h80, 32'h2000, 2'b10), 64'h0};
        set_c = {mk_way(1'b1, 27'h80, 32'h2000, 2'b00), mk_way(1'b1, 27'h80, 32'h3000, 2'b00)};
        set_d = {64'h0, mk_way(1'b1, 27'h80, 32'h3000, 2'b01)};
        set_e = {mk_way(1'b1, 27'h80, 32'h4444, 2'b00), 64'h0};

        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = 32'h0; stall = 1'b0;
        upd_pc = 32'h1004; write_en = 1'b0; write_set = '0; write_alloc = 1'b0;
        step();
        step();
        chk_pred("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset.old_set", old_set, 128'h0);
        chk("reset.lru", 128'(lru_victim), 128'd0);

        rst = 1'b0; lookup_valid = 1'b1; lookup_pc = 32'h1004;
        step();
        chk_pred("miss", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1008);

        lookup_valid = 1'b0; write_en = 1'b1; write_set = set_a; write_alloc = 1'b1;
        #1;
        chk("pre_write.hit1", 128'(upd_hit1), 128'd0);
        step();
        write_en = 1'b0; write_alloc = 1'b0;
        chk("idle.valid", 128'(pred_valid), 128'd0);
        chk("write_a.old_set", old_set, set_a);
        chk("write_a.lru", 128'(lru_victim), 128'd1);
        chk("write_a.hit1", 128'(upd_hit1), 128'd1);
        chk("write_a.hit2", 128'(upd_hit2), 128'd0);

        lookup_valid = 1'b1; lookup_pc = 32'h1004;
        step();
        chk_pred("hit_a", 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h2000);
        chk("hit_a.lru", 128'(lru_victim), 128'd1);

        // Bypass with a not-taken FSM; upd side must still show set_a.
        write_en = 1'b1; write_set = set_b;
        #1;
        chk("bypass.old_set_pre", old_set, set_a);
        step();
        write_en = 1'b0;
        chk_pred("bypass_b", 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h1008);
        chk("bypass_b.old_set_post", old_set, set_b);

        lookup_valid = 1'b0; write_en = 1'b1; write_set = set_c; write_alloc = 1'b1;
        step();
        write_en = 1'b0; write_alloc = 1'b0;
        chk("both.hit1", 128'(upd_hit1), 128'd1);
        chk("both.hit2", 128'(upd_hit2), 128'd0);
        chk("both.lru_alloc", 128'(lru_victim), 128'd0);
        lookup_valid = 1'b1;
        step();
        chk_pred("both", 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h2000);
        chk("both.lru_hit", 128'(lru_victim), 128'd1);

        lookup_valid = 1'b0; write_en = 1'b1; write_set = set_d;
        step();
        write_en = 1'b0;
        chk("way2.lru_noalloc", 128'(lru_victim), 128'd1);
        chk("way2.hit2", 128'(upd_hit2), 128'd1);
        lookup_valid = 1'b1;
        step();
        chk_pred("way2", 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000);
        chk("way2.lru_hit", 128'(lru_victim), 128'd0);

        // Allocating write beats a same-index hit LRU update.
        write_en = 1'b1; write_set = set_d; write_alloc = 1'b1;
        step();
        write_en = 1'b0; write_alloc = 1'b0;
        chk("alloc_wins.lru", 128'(lru_victim), 128'd1);

        // Write to another index must not be forwarded.
        upd_pc = 32'h1008; write_en = 1'b1; write_set = set_e;
        step();
        write_en = 1'b0;
        chk_pred("other_idx", 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000);
        chk("other_idx.old_set", old_set, set_e);

        upd_pc = 32'h1004;
        chk("other_idx.lru", 128'(lru_victim), 128'd0);
        stall = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'hFFFF_FFFC;
        write_en = 1'b1; write_set = set_d; write_alloc = 1'b1;
        step();
        write_en = 1'b0; write_alloc = 1'b0;
        chk_pred("stall1", 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000);
        chk("stall.write_lru", 128'(lru_victim), 128'd1);
        lookup_pc = 32'h0000_1000;
        step();
        chk_pred("stall2", 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000);
        lookup_valid = 1'b0; lookup_pc = 32'h1004;
        step();
        chk_pred("stall3", 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000);
        chk("stall.lru_hold", 128'(lru_victim), 128'd1);

        stall = 1'b0; lookup_valid = 1'b0;
        step();
        chk("unstall.valid", 128'(pred_valid), 128'd0);

        lookup_valid = 1'b1; lookup_pc = 32'hFFFF_FFFC;
        step();
        chk_pred("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

        lookup_pc = 32'h1004;
        step();
        chk("pre_rst.valid", 128'(pred_valid), 128'd1);
        rst = 1'b1; write_en = 1'b1; write_set = set_a; write_alloc = 1'b1;
        step();
        rst = 1'b0; write_en = 1'b0; write_alloc = 1'b0; lookup_valid = 1'b0;
        chk_pred("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst2.old_set", old_set, 128'h0);
        chk("rst2.lru", 128'(lru_victim), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_lookup.md
# btb_lookup

Read side of the two-way branch target buffer, and the owner of its storage. Holds 8 sets of 128-bit entries plus per-set LRU bits. Each cycle it indexes a set with the fetch PC, compares tags in both ways and registers a prediction (hit, way, taken, target, next PC) for fetch. It also serves the write side: supplies the addressed old set and LRU victim, and commits the rebuilt set on a write strobe.

## Interface
- Parameters
  - NSETS, default 8: number of sets; must equal 2^IDX_W.
  - IDX_W, default 3: index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2], 27 bits at default.
- Ports
  - clk: in, 1. Single clock.
  - rst: in, 1. Synchronous, active-high reset.
  - lookup_valid: in, 1. lookup_pc is valid this cycle.
  - lookup_pc: in, 32. Fetch PC.
  - stall: in, 1. Hold the output stage and ignore lookup.
  - pred_valid: out, 1. Registered: prediction present.
  - pred_hit: out, 1. Tag match in a valid way.
  - pred_way: out, 1. 0 = way1 (bits 127:64), 1 = way2 (bits 63:0).
  - pred_taken: out, 1. Hit and the way's FSM is in a taken state.
  - pred_target: out, 32. Target of the hit way, else 0.
  - pred_next_pc: out, 32. pred_target if pred_taken, else pc+4.
  - upd_pc: in, 32. PC being resolved by the write side.
  - old_set: out, 128. Combinational: set at upd_pc index.
  - lru_victim: out, 1. Combinational: LRU bit of that set (0 = way1).
  - upd_hit1, upd_hit2: out, 1 each. Combinational tag match of upd_pc in way1/way2; way1 wins if both match.
  - write_en: in, 1. Commit write_set to set at upd_pc index.
  - write_set: in, 128. Rebuilt set from the write side.
  - write_alloc: in, 1. The write inserted a new entry; qualifies LRU flip.

## Operation
- Set layout per way (way1 at offset 64, way2 at offset 0): valid [63], tag [62:36], target [35:4], fsm [3:2], [1:0] reserved, written 0, ignored on read.
- FSM taken states: 2'b00 and 2'b01. Not taken: 2'b10 and 2'b11.
- Lookup compares tag against both ways; hit requires valid=1. Both ways matching resolves to way1, pred_way=0.
- Miss drives pred_hit=0, pred_taken=0, pred_target=0, pred_way=0, pred_next_pc=pc+4. Addition wraps mod 2^32.
- Write: on write_en, array[idx(upd_pc)] <= write_set. If write_alloc, lru[idx] <= ~lru[idx].
- LRU on lookup: an accepted lookup that hits sets lru[idx] <= ~pred_way, so the victim is the other way.
- Same-cycle write and lookup hit to one index: the write_alloc rule wins. If write_alloc=0, the lookup rule applies.
- Bypass: a lookup in the same cycle as write_en to the same index evaluates against write_set, not the stale array. A different index reads the array.
- Upd-side outputs never bypass. They reflect the array before this cycle's write.

## Timing
- Lookup latency is 1 cycle. An accepted lookup (lookup_valid & ~stall) at edge N produces pred_* valid after edge N.
- stall=1: all pred_* hold, lookup_valid is ignored, and no lookup-driven LRU update occurs. Writes still commit during stall.
- lookup_valid=0 & ~stall: pred_valid <= 0. Other pred_* fields may hold.
- Reset: all valid bits cleared (full array zeroed), all LRU = 0, and every pred_* output = 0, including pred_next_pc.
- rst takes priority over write_en and lookup in the same cycle.
- Upd-side outputs are combinational with no latency.

## Structure
- Package btb_pkg: IDX_W, tag/target widths, way field bit offsets, FSM state constants, is_taken() function, and a way_t struct {valid, tag, target, fsm, rsvd}.
- Sub-module btb_way_match: one way's unpack, tag compare and taken decode. Instantiate 2× for lookup and 2× for the upd port.
- Array and LRU are flops, not an inferred RAM, so reset can clear them.

## Test plan
- Reset, then lookup 0x0000_1004: next cycle pred_valid=1, pred_hit=0, pred_next_pc=0x0000_1008.
- write_en with upd_pc=0x1004, write_set way1 = {valid 1, tag 0x1004>>5, target 0x2000, fsm 00}, write_alloc=1; then lookup 0x1004 → hit, way 0, taken, next_pc 0x2000; lru[1] goes 0→1 on the write, and stays 1 after the hit.
- Same entry with fsm=2'b10 → pred_hit=1, pred_taken=0, pred_next_pc=0x1008.
- Write and lookup of 0x1004 in the same cycle → prediction reflects write_set (bypass). old_set that cycle still shows the pre-write value.
- Both ways valid with equal tags, targets 0x2000 and 0x3000 → way 0, target 0x2000.
- Accept a lookup, then hold stall=1 for 3 cycles while changing lookup_pc → pred_* unchanged; then deassert stall with lookup_valid=0 → pred_valid=0.
